speed_selector: RTL and testbench

Upstream control stage for `blink_controller`: turns two raw push-buttons into the 16-bit `speed` value, in milliseconds, that `blink_controller` consumes. Each button is synchronised and debounced. A press steps `speed` up or down with saturation. Holding a button auto-repeats. Pressing both buttons restores the initial speed.

---
 rtl/speed_pkg.sv | 19 +
 rtl/debounce.sv | 40 ++++
 rtl/speed_selector.sv | 159 +++++++++++++++
 tb/tb_speed_selector.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/speed_pkg.sv
// Shared types and helpers for the speed selector: value type, FSM state
// encoding and the millisecond prescaler length.
package speed_pkg;

  typedef logic [15:0] speed_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2,
    BOTH   = 2'd3
  } sel_state_e;

  // Clock cycles per millisecond, never less than one.
  function automatic int ms_cycles(input int clk_freq_hz);
    return (clk_freq_hz / 1000 < 1) ? 1 : clk_freq_hz / 1000;
  endfunction

endpackage

// File: rtl/debounce.sv
// Millisecond-tick debouncer: the output level follows a synchronised input
// only after it has disagreed for DEBOUNCE_MS consecutive ticks.
module debounce #(
  parameter int DEBOUNCE_MS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_tick,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int DW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

  logic [DW-1:0] cnt;

  // rise is registered together with dout so both change on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      dout <= 1'b0;
      rise <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (din == dout) begin
        cnt <= '0;
      end else if (ms_tick) begin
        if (cnt == DW'(DEBOUNCE_MS - 1)) begin
          dout <= din;
          rise <= din;
          cnt  <= '0;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/speed_selector.sv
// Two-button speed control: synchronises and debounces the buttons, then
// steps a saturating ms period up/down with hold-to-repeat and both-to-restore.
module speed_selector
  import speed_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 100,
  parameter int SPEED_INIT  = 5,
  parameter int SPEED_MIN   = 1,
  parameter int SPEED_MAX   = 1000,
  parameter int SPEED_STEP  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [15:0] speed,
  output logic        speed_changed,
  output logic [1:0]  state_dbg
);

  localparam int MS     = ms_cycles(CLK_FREQ_HZ);
  localparam int PW     = (MS > 1) ? $clog2(MS) : 1;
  localparam int HR_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int CW     = $clog2(HR_MAX + 1);

  logic [1:0]    sync_up;
  logic [1:0]    sync_dn;
  logic [PW-1:0] pre_cnt;
  logic          ms_tick;
  logic          lvl_up;
  logic          lvl_dn;
  logic          rise_up;
  logic          rise_dn;

  sel_state_e    state;
  logic          dir_up;
  logic [CW-1:0] hold_cnt;

  logic          step_dir_up;
  logic [16:0]   up_sum;
  speed_t        step_val;
  logic          act_lvl;
  logic          oth_lvl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_up <= 2'b00;
      sync_dn <= 2'b00;
    end else begin
      sync_up <= {sync_up[0], btn_up};
      sync_dn <= {sync_dn[0], btn_down};
    end
  end

  assign ms_tick = (pre_cnt == PW'(MS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (ms_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_up (
    .clk     (clk),
    .rst     (rst),
    .ms_tick (ms_tick),
    .din     (sync_up[1]),
    .dout    (lvl_up),
    .rise    (rise_up)
  );

  debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_dn (
    .clk     (clk),
    .rst     (rst),
    .ms_tick (ms_tick),
    .din     (sync_dn[1]),
    .dout    (lvl_dn),
    .rise    (rise_dn)
  );

  // Saturating step, evaluated in 17 bits so the up path can never wrap.
  always_comb begin
    step_dir_up = (state == IDLE) ? rise_up : dir_up;
    up_sum      = {1'b0, speed} + 17'(SPEED_STEP);
    step_val    = speed;
    if (step_dir_up) begin
      step_val = (up_sum > 17'(SPEED_MAX)) ? speed_t'(SPEED_MAX) : up_sum[15:0];
    end else begin
      step_val = ({1'b0, speed} < 17'(SPEED_MIN) + 17'(SPEED_STEP)) ?
                 speed_t'(SPEED_MIN) : speed - speed_t'(SPEED_STEP);
    end
    act_lvl = dir_up ? lvl_up : lvl_dn;
    oth_lvl = dir_up ? lvl_dn : lvl_up;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      dir_up        <= 1'b0;
      hold_cnt      <= '0;
      speed         <= speed_t'(SPEED_INIT);
      speed_changed <= 1'b0;
    end else begin
      speed_changed <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_up || rise_dn) begin
            if (lvl_up && lvl_dn) begin
              speed         <= speed_t'(SPEED_INIT);
              speed_changed <= (speed != speed_t'(SPEED_INIT));
              state         <= BOTH;
            end else begin
              dir_up        <= rise_up;
              speed         <= step_val;
              speed_changed <= (step_val != speed);
              hold_cnt      <= CW'(HOLD_MS);
              state         <= HOLD;
            end
          end
        end
        HOLD, REPEAT: begin
          // The other button wins over a simultaneous release so its press is not lost.
          if (oth_lvl) begin
            speed         <= speed_t'(SPEED_INIT);
            speed_changed <= (speed != speed_t'(SPEED_INIT));
            state         <= BOTH;
          end else if (!act_lvl) begin
            state <= IDLE;
          end else if (ms_tick) begin
            if (hold_cnt <= CW'(1)) begin
              speed         <= step_val;
              speed_changed <= (step_val != speed);
              hold_cnt      <= CW'(REPEAT_MS);
              state         <= REPEAT;
            end else begin
              hold_cnt <= hold_cnt - CW'(1);
            end
          end
        end
        BOTH: begin
          if (!lvl_up && !lvl_dn) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_speed_selector.sv
// Directed bench for speed_selector with a 10-cycle ms tick, 2 ms debounce,
// 5 ms hold and 2 ms repeat; expected speeds are hand-derived.
module tb_speed_selector;
  import speed_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_up;
  logic        btn_down;
  logic [15:0] speed;
  logic        speed_changed;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int max_speed = 0;
  logic [15:0] exp_q[$];

  speed_selector #(
    .CLK_FREQ_HZ (10_000),
    .DEBOUNCE_MS (2),
    .HOLD_MS     (5),
    .REPEAT_MS   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .speed         (speed),
    .speed_changed (speed_changed),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    rst      = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: every pulse must carry the next expected speed
  always @(negedge clk) begin
    if (int'(speed) > max_speed) max_speed = int'(speed);
    if (speed_changed === 1'b1) begin
      pulses++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: pulse with speed %0d, expected no pulse", speed);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (speed !== e) begin
          n_fail++;
          $display("FAIL scoreboard_value: speed %0d, expected %0d", speed, e);
        end
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_up(input int hold_c, input int gap_c);
    btn_up = 1'b1;
    cyc(hold_c);
    btn_up = 1'b0;
    cyc(gap_c);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(3);
  endtask

  task automatic check_queue_empty(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_queue: %0d expected steps missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      btn_up   = i[0];
      btn_down = i[1];
      cyc(1);
      if (speed !== 16'd5 || speed_changed !== 1'b0 || state_dbg !== IDLE) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_hold: %0d bad cycles, required 0", bad);
    end
    btn_up   = 1'b0;
    btn_down = 1'b0;
    rst      = 1'b1;
    cyc(40);
    n_checks++;
    if (speed !== 16'd5) begin
      n_fail++;
      $display("FAIL reset_release_speed: got %0d required 5", speed);
    end
    n_checks++;
    if (state_dbg !== IDLE || speed_changed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_state: state %0d changed %0b, required 0 0", state_dbg, speed_changed);
    end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = pulses;
    for (int i = 0; i < 2; i++) begin
      btn_down = 1'b1;
      cyc(5);
      btn_down = 1'b0;
      cyc(5);
    end
    cyc(50);
    n_checks++;
    if (speed !== 16'd5 || pulses != p0) begin
      n_fail++;
      $display("FAIL bounce: speed %0d pulses %0d, required 5 0", speed, pulses - p0);
    end
  endtask

  task automatic test_single_press();
    int p0;
    int lat;
    p0  = pulses;
    lat = -1;
    exp_q.push_back(16'd10);
    btn_up = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (lat < 0 && speed !== 16'd5) lat = i + 1;
    end
    n_checks++;
    if (state_dbg !== HOLD) begin
      n_fail++;
      $display("FAIL single_state_hold: got %0d required %0d", state_dbg, HOLD);
    end
    btn_up = 1'b0;
    cyc(60);
    n_checks++;
    if (lat < 1 || lat > 32) begin
      n_fail++;
      $display("FAIL single_latency: got %0d cycles, required 1..32", lat);
    end
    n_checks++;
    if (speed !== 16'd10 || pulses - p0 != 1) begin
      n_fail++;
      $display("FAIL single_value: speed %0d pulses %0d, required 10 1", speed, pulses - p0);
    end
    n_checks++;
    if (state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL single_state_idle: got %0d required 0", state_dbg);
    end
    check_queue_empty("single");
  endtask

  // Raw hold of 10 ms keeps the debounced level high from ~2 ms to ~12 ms.
  task automatic test_auto_repeat();
    int p0;
    do_reset();
    p0 = pulses;
    exp_q.push_back(16'd10);
    exp_q.push_back(16'd15);
    exp_q.push_back(16'd20);
    exp_q.push_back(16'd25);
    btn_up = 1'b1;
    cyc(95);
    n_checks++;
    if (state_dbg !== REPEAT) begin
      n_fail++;
      $display("FAIL repeat_state: got %0d required %0d", state_dbg, REPEAT);
    end
    cyc(5);
    btn_up = 1'b0;
    cyc(60);
    n_checks++;
    if (speed !== 16'd25 || pulses - p0 != 4) begin
      n_fail++;
      $display("FAIL repeat_value: speed %0d pulses %0d, required 25 4", speed, pulses - p0);
    end
    check_queue_empty("repeat");
  endtask

  task automatic test_reset_mid_hold();
    exp_q.push_back(16'd30);
    btn_up = 1'b1;
    cyc(40);
    rst = 1'b0;
    #1;
    n_checks++;
    if (speed !== 16'd5 || speed_changed !== 1'b0 || state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL midhold_reset: speed %0d changed %0b state %0d, required 5 0 0",
               speed, speed_changed, state_dbg);
    end
    cyc(2);
    exp_q.push_back(16'd10);
    rst = 1'b1;
    cyc(40);
    n_checks++;
    if (speed !== 16'd10) begin
      n_fail++;
      $display("FAIL midhold_requalify: speed %0d, required 10", speed);
    end
    btn_up = 1'b0;
    cyc(60);
    check_queue_empty("midhold");
  endtask

  task automatic test_saturation();
    int p0;
    int v;
    do_reset();
    p0 = pulses;
    exp_q.push_back(16'd1);
    btn_down = 1'b1;
    cyc(100);
    btn_down = 1'b0;
    cyc(60);
    n_checks++;
    if (speed !== 16'd1 || pulses - p0 != 1) begin
      n_fail++;
      $display("FAIL sat_low: speed %0d pulses %0d, required 1 1", speed, pulses - p0);
    end
    check_queue_empty("sat_low");

    p0 = pulses;
    max_speed = 0;
    v = 1;
    while (v != 1000) begin
      v = (v + 5 > 1000) ? 1000 : v + 5;
      exp_q.push_back(16'(v));
    end
    btn_up = 1'b1;
    cyc(4500);
    btn_up = 1'b0;
    cyc(60);
    n_checks++;
    if (speed !== 16'd1000 || pulses - p0 != 200) begin
      n_fail++;
      $display("FAIL sat_high: speed %0d pulses %0d, required 1000 200", speed, pulses - p0);
    end
    n_checks++;
    if (max_speed > 1000) begin
      n_fail++;
      $display("FAIL sat_high_max: peak %0d, required <= 1000", max_speed);
    end
    check_queue_empty("sat_high");

    p0 = pulses;
    press_up(40, 60);
    n_checks++;
    if (speed !== 16'd1000 || pulses != p0 || state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL sat_press_at_max: speed %0d pulses %0d state %0d, required 1000 0 0",
               speed, pulses - p0, state_dbg);
    end
  endtask

  task automatic test_both();
    int p0;
    do_reset();
    p0 = pulses;
    btn_up   = 1'b1;
    btn_down = 1'b1;
    cyc(40);
    n_checks++;
    if (state_dbg !== BOTH || speed !== 16'd5 || pulses != p0) begin
      n_fail++;
      $display("FAIL both_at_init: state %0d speed %0d pulses %0d, required 3 5 0",
               state_dbg, speed, pulses - p0);
    end
    btn_up   = 1'b0;
    btn_down = 1'b0;
    cyc(60);

    for (int k = 1; k <= 7; k++) begin
      exp_q.push_back(16'(5 + 5 * k));
      press_up(40, 60);
    end
    n_checks++;
    if (speed !== 16'd40) begin
      n_fail++;
      $display("FAIL both_preload: speed %0d, required 40", speed);
    end

    exp_q.push_back(16'd45);
    btn_up = 1'b1;
    cyc(35);
    n_checks++;
    if (speed !== 16'd45) begin
      n_fail++;
      $display("FAIL both_up_step: speed %0d, required 45", speed);
    end
    exp_q.push_back(16'd5);
    p0 = pulses;
    btn_down = 1'b1;
    cyc(40);
    n_checks++;
    if (speed !== 16'd5 || pulses - p0 != 1 || state_dbg !== BOTH) begin
      n_fail++;
      $display("FAIL both_restore: speed %0d pulses %0d state %0d, required 5 1 3",
               speed, pulses - p0, state_dbg);
    end
    cyc(100);
    btn_down = 1'b0;
    cyc(60);
    n_checks++;
    if (speed !== 16'd5 || pulses - p0 != 1 || state_dbg !== BOTH) begin
      n_fail++;
      $display("FAIL both_no_steps: speed %0d pulses %0d state %0d, required 5 1 3",
               speed, pulses - p0, state_dbg);
    end
    btn_up = 1'b0;
    cyc(60);
    n_checks++;
    if (state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL both_exit: state %0d, required 0", state_dbg);
    end
    exp_q.push_back(16'd10);
    press_up(40, 60);
    n_checks++;
    if (speed !== 16'd10) begin
      n_fail++;
      $display("FAIL both_new_press: speed %0d, required 10", speed);
    end
    check_queue_empty("both");
  endtask

  initial begin
    cyc(3);
    test_reset();
    test_bounce();
    test_single_press();
    test_auto_repeat();
    test_reset_mid_hold();
    test_saturation();
    test_both();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
